// File: rtl/adc_sched_pkg.sv
// Shared constants for the ADC sample scheduler: state encoding, default timings
// and helpers for sizing id and counter fields.
package adc_sched_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_READ  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;
   localparam logic [2:0] ST_GAP   = 3'd5;

   localparam int DEF_NREQ        = 4;
   localparam int DEF_DW          = 8;
   localparam int DEF_CONVST_LOW  = 4;
   localparam int DEF_RD_LOW      = 3;
   localparam int DEF_TIMEOUT_CYC = 400;
   localparam int DEF_GAP         = 2;

   function automatic int id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, with wrap.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx,
   output logic            any
);

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         int j;
         logic [IW-1:0] jj;
         j = int'(ptr) + i;
         if (j >= NREQ) j = j - NREQ;
         jj = IW'(j);
         if (!any && req[jj]) begin
            any       = 1'b1;
            grant[jj] = 1'b1;
            idx       = jj;
         end
      end
   end

endmodule

// File: rtl/adc_sample_scheduler.sv
// Shares one parallel ADC between NREQ requesters, one conversion per grant,
// driving CONVST/CS/RD and returning each sample tagged with its requester id.
//
// state    | meaning
// ST_IDLE  | wait for any Req, latch round-robin grant
// ST_START | CONVST low for CONVST_LOW cycles
// ST_WAIT  | wait for synced BUSY low, bounded by TIMEOUT_CYC
// ST_READ  | CS/RD low for RD_LOW cycles, D captured on the last one
// ST_DONE  | one-cycle DoutValid/Ack, advance RR pointer
// ST_GAP   | GAP idle cycles before the next grant
module adc_sample_scheduler
   import adc_sched_pkg::*;
#(
   parameter int NREQ        = DEF_NREQ,
   parameter int DW          = DEF_DW,
   parameter int CONVST_LOW  = DEF_CONVST_LOW,
   parameter int RD_LOW      = DEF_RD_LOW,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int GAP         = DEF_GAP
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic [NREQ-1:0]         Req,
   output logic [NREQ-1:0]         Ack,
   input  logic                    BUSY,
   input  logic [DW-1:0]           D,
   output logic                    CONVST,
   output logic                    CS,
   output logic                    RD,
   output logic [DW-1:0]           Dout,
   output logic [id_w(NREQ)-1:0]   DoutId,
   output logic                    DoutValid,
   output logic                    DoutErr
);

   localparam int IW = id_w(NREQ);
   localparam int CNT_MAX = max_int(max_int(CONVST_LOW, RD_LOW), max_int(TIMEOUT_CYC, GAP));
   localparam int CW = $clog2(CNT_MAX + 1);

   logic [2:0]      state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            err_nxt;
   logic            busy_meta, busy_s;
   logic            wait_first;
   logic [IW-1:0]   rr_ptr, grant_id, arb_idx;
   logic [NREQ-1:0] grant_oh, arb_grant;
   logic            arb_any;

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
      .req   (Req),
      .ptr   (rr_ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   // Counter is reloaded with TIMEOUT_CYC-1 on WAIT entry, so that value marks
   // the first WAIT cycle, where the synchronizer output is still stale.
   assign wait_first = (cnt == CW'(TIMEOUT_CYC - 1));

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      err_nxt   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (arb_any) begin
               state_nxt = ST_START;
               cnt_nxt   = CW'(CONVST_LOW - 1);
            end
         end
         ST_START: begin
            if (cnt == '0) begin
               state_nxt = ST_WAIT;
               cnt_nxt   = CW'(TIMEOUT_CYC - 1);
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_WAIT: begin
            if (!wait_first && !busy_s) begin
               state_nxt = ST_READ;
               cnt_nxt   = CW'(RD_LOW - 1);
            end else if (cnt == '0) begin
               state_nxt = ST_DONE;
               err_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_READ: begin
            if (cnt == '0) begin
               state_nxt = ST_DONE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_DONE: begin
            if (GAP == 0) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else begin
               state_nxt = ST_GAP;
               cnt_nxt   = CW'(GAP - 1);
            end
         end
         ST_GAP: begin
            if (cnt == '0) begin
               state_nxt = ST_IDLE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Pin strobes and result flags are registered from the next state so they
   // line up exactly with the state they belong to and never glitch.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         busy_meta <= 1'b0;
         busy_s    <= 1'b0;
         rr_ptr    <= '0;
         grant_id  <= '0;
         grant_oh  <= '0;
         CONVST    <= 1'b1;
         CS        <= 1'b1;
         RD        <= 1'b1;
         Ack       <= '0;
         Dout      <= '0;
         DoutId    <= '0;
         DoutValid <= 1'b0;
         DoutErr   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         busy_meta <= BUSY;
         busy_s    <= busy_meta;
         if (state == ST_IDLE && arb_any) begin
            grant_id <= arb_idx;
            grant_oh <= arb_grant;
         end
         CONVST    <= (state_nxt != ST_START);
         CS        <= (state_nxt != ST_READ);
         RD        <= (state_nxt != ST_READ);
         DoutValid <= (state_nxt == ST_DONE);
         Ack       <= (state_nxt == ST_DONE) ? grant_oh : '0;
         if (state_nxt == ST_DONE) begin
            Dout    <= err_nxt ? '0 : D;
            DoutId  <= grant_id;
            DoutErr <= err_nxt;
         end
         if (state == ST_DONE) begin
            rr_ptr <= (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Bench for adc_sample_scheduler: behavioural ADC model plus a scoreboard of
// expected (id, data, err) results checked whenever DoutValid fires.
module tb_adc_sample_scheduler;

   localparam int NREQ = 4;
   localparam int DW   = 8;

   logic          Clk = 1'b0;
   logic          Rst = 1'b1;
   logic [3:0]    Req = '0;
   logic [3:0]    Ack;
   logic          BUSY = 1'b0;
   logic [7:0]    D = '0;
   logic          CONVST, CS, RD;
   logic [7:0]    Dout;
   logic [1:0]    DoutId;
   logic          DoutValid, DoutErr;

   adc_sample_scheduler #(
      .NREQ(4), .DW(8), .CONVST_LOW(4), .RD_LOW(3), .TIMEOUT_CYC(400), .GAP(2)
   ) dut (
      .Clk(Clk), .Rst(Rst), .Req(Req), .Ack(Ack), .BUSY(BUSY), .D(D),
      .CONVST(CONVST), .CS(CS), .RD(RD), .Dout(Dout), .DoutId(DoutId),
      .DoutValid(DoutValid), .DoutErr(DoutErr)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [1:0] id;
      logic [7:0] data;
      logic       err;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] adc_q[$];

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_vec++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, expv);
      end
   endtask

   task automatic expect_conv(input int id, input logic [7:0] data, input logic err);
      exp_t e;
      e.id   = 2'(id);
      e.data = err ? 8'h00 : data;
      e.err  = err;
      adc_q.push_back(data);
      exp_q.push_back(e);
   endtask

   // ADC model: BUSY rises while CONVST is low and stays up busy_len cycles after release
   logic busy_en    = 1'b1;
   logic busy_stuck = 1'b0;
   int   busy_len   = 3;
   int   busy_cnt   = 0;
   logic prev_convst_adc = 1'b1;

   always @(negedge Clk) begin
      if (!CONVST && prev_convst_adc)
         D = (adc_q.size() > 0) ? adc_q.pop_front() : 8'hEE;
      if (!CONVST) begin
         BUSY     = busy_en;
         busy_cnt = busy_len;
      end else if (busy_stuck) begin
         BUSY = 1'b1;
      end else if (busy_cnt > 0) begin
         BUSY     = 1'b1;
         busy_cnt = busy_cnt - 1;
      end else begin
         BUSY = 1'b0;
      end
      prev_convst_adc = CONVST;
   end

   // Output monitor and scoreboard
   int   n_valid = 0;
   int   n_rise = 0;
   int   since_valid = 0;
   int   rel_cnt = 0;
   int   last_rel = 0;
   int   cv_run = 0;
   int   cs_run = 0;
   int   ovl = 0;
   int   stray = 0;
   int   gap_mode = 0;
   int   period_mode = 0;
   logic prev_convst = 1'b1;

   always @(negedge Clk) begin
      exp_t e;
      if (CONVST && !prev_convst) begin
         rel_cnt = 0;
         n_rise++;
      end else begin
         rel_cnt++;
      end

      if (!CONVST && (!CS || !RD)) ovl++;
      if (CS !== RD) ovl++;

      if (DoutValid) begin
         n_valid++;
         last_rel = rel_cnt;
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("dout_id", DoutId, e.id);
            chk("dout", Dout, e.data);
            chk("dout_err", DoutErr, e.err);
            chk("ack", Ack, 32'd1 << e.id);
         end
         if (period_mode == 2) chk("period", since_valid + 1, 13);
         if (period_mode == 1) period_mode = 2;
         if (gap_mode == 1) gap_mode = 2;
         since_valid = 0;
      end else begin
         since_valid++;
         if (Ack != 4'b0000) stray++;
      end

      if (!CONVST && prev_convst && gap_mode == 2) chk("gap", since_valid, 4);

      if (!CONVST) begin
         cv_run++;
      end else if (cv_run != 0) begin
         if (!Rst) chk("convst_width", cv_run, 4);
         cv_run = 0;
      end
      if (!CS) begin
         cs_run++;
      end else if (cs_run != 0) begin
         if (!Rst) chk("cs_width", cs_run, 3);
         cs_run = 0;
      end
      prev_convst = CONVST;
   end

   task automatic wait_valids(input int n, input int budget, input string tag);
      int start;
      int cyc;
      start = n_valid;
      cyc = 0;
      while ((n_valid - start) < n && cyc < budget) begin
         @(negedge Clk); #1;
         cyc++;
      end
      if ((n_valid - start) < n) chk({tag, "_timeout"}, n_valid - start, n);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int start;
      int cyc;

      // reset state
      repeat (3) @(negedge Clk);
      #1;
      chk("rst_convst", CONVST, 1);
      chk("rst_cs", CS, 1);
      chk("rst_rd", RD, 1);
      chk("rst_ack", Ack, 0);
      chk("rst_dout", Dout, 0);
      chk("rst_doutid", DoutId, 0);
      chk("rst_valid", DoutValid, 0);
      chk("rst_err", DoutErr, 0);
      Rst = 1'b0;
      repeat (2) @(negedge Clk);
      #1;

      // all requesters active: strict rotation from pointer 0
      busy_len = 3;
      for (int k = 0; k < 5; k++) expect_conv(k % 4, 8'((k % 4) * 16 + k), 1'b0);
      gap_mode = 1;
      Req = 4'b1111;
      wait_valids(5, 400, "rr");
      Req = 4'b0000;
      gap_mode = 0;
      repeat (10) @(negedge Clk);
      #1;
      chk("dout_hold", Dout, 8'h04);
      chk("doutid_hold", DoutId, 0);

      // single requester 2, long BUSY
      busy_len = 50;
      expect_conv(2, 8'hA5, 1'b0);
      Req = 4'b0100;
      wait_valids(1, 300, "single");
      Req = 4'b0000;
      repeat (5) @(negedge Clk);
      #1;

      // BUSY stuck high: timeout, then recovery on the next grant
      busy_stuck = 1'b1;
      busy_len = 5;
      expect_conv(0, 8'hFF, 1'b1);
      expect_conv(0, 8'h3C, 1'b0);
      Req = 4'b0001;
      wait_valids(1, 600, "timeout");
      chk("timeout_wait", last_rel, 400);
      busy_stuck = 1'b0;
      wait_valids(1, 300, "recover");
      Req = 4'b0000;
      repeat (5) @(negedge Clk);
      #1;

      // Req[1] dropped during WAIT with Req[3] pending (pointer is 1)
      busy_len = 30;
      expect_conv(1, 8'h51, 1'b0);
      expect_conv(3, 8'h53, 1'b0);
      Req = 4'b1010;
      start = n_rise;
      cyc = 0;
      while (n_rise == start && cyc < 100) begin
         @(negedge Clk); #1;
         cyc++;
      end
      if (n_rise == start) chk("drop_start_timeout", n_rise - start, 1);
      repeat (3) @(negedge Clk);
      #1;
      Req[1] = 1'b0;
      wait_valids(2, 400, "drop");
      Req = 4'b0000;
      repeat (5) @(negedge Clk);
      #1;

      // reset during READ aborts the conversion and clears the pointer
      busy_len = 5;
      adc_q.push_back(8'h77);
      Req = 4'b0100;
      cyc = 0;
      while (CS && cyc < 200) begin
         @(negedge Clk); #1;
         cyc++;
      end
      chk("read_reached", CS, 0);
      Rst = 1'b1;
      @(negedge Clk);
      #1;
      chk("abort_convst", CONVST, 1);
      chk("abort_cs", CS, 1);
      chk("abort_rd", RD, 1);
      chk("abort_valid", DoutValid, 0);
      chk("abort_ack", Ack, 0);
      Req = 4'b1111;
      Rst = 1'b0;
      expect_conv(0, 8'h0F, 1'b0);
      wait_valids(1, 300, "post_rst");
      Req = 4'b0000;
      repeat (5) @(negedge Clk);
      #1;

      // continuous Req[0] with BUSY never asserted: minimum period
      busy_en = 1'b0;
      busy_len = 0;
      for (int k = 0; k < 3; k++) expect_conv(0, 8'(8'hC0 + k), 1'b0);
      period_mode = 1;
      Req = 4'b0001;
      wait_valids(3, 200, "period");
      Req = 4'b0000;
      period_mode = 0;
      repeat (20) @(negedge Clk);
      #1;

      chk("exp_q_empty", exp_q.size(), 0);
      chk("adc_q_empty", adc_q.size(), 0);
      chk("strobe_overlap", ovl, 0);
      chk("stray_ack", stray, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
